ps2_keyboard_rx: RTL and testbench

Receives the raw PS/2 keyboard line pair and turns scan codes (set 2) into ASCII bytes for the passphrase buffer in the RSA key-unlock path. It sits directly upstream of the decryptor's keyboard-buffering state. It drives that state's `ps2_data`/`ps2_valid`/`ps2_done`/`ps2_reset` inputs, with Enter marking passphrase completion and Escape clearing it. Key releases, extended prefixes, unmapped keys and corrupted frames never reach the consumer.

---
 rtl/ps2_keyboard_rx.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and glitch-filters the line pair, frames set-2 scan codes
// and emits ASCII key presses. Define PS2_SHIFT_EN to enable shift tracking (uppercase letters).
module ps2_keyboard_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] ps2_data_o,
  output logic       ps2_valid_o,
  output logic       ps2_done_o,
  output logic       ps2_reset_o,
  output logic       parity_err_o
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DECODE
  } state_e;

  logic [1:0]    ck_sync_q;
  logic [1:0]    dt_sync_q;
  logic          flt_q;
  logic          flt_prev_q;
  logic [FW-1:0] flt_cnt_q;
  logic          fall;
  logic          dat_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_sync_q <= '1;
      dt_sync_q <= '1;
    end else begin
      ck_sync_q <= {ck_sync_q[0], ps2_clk_i};
      dt_sync_q <= {dt_sync_q[0], ps2_dat_i};
    end
  end

  // Filtered level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_q      <= 1'b1;
      flt_prev_q <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      flt_prev_q <= flt_q;
      if (ck_sync_q[1] == flt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FILT_LAST) begin
        flt_q     <= ck_sync_q[1];
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  assign fall  = flt_prev_q & ~flt_q;
  assign dat_s = dt_sync_q[1];

  // Returns {hit, ascii}; hit=0 for unmapped codes.
  function automatic logic [8:0] lookup(input logic [7:0] code);
    logic [8:0] r;
    r = '0;
    case (code)
      8'h1C: r = {1'b1, 8'h61}; 8'h32: r = {1'b1, 8'h62}; 8'h21: r = {1'b1, 8'h63};
      8'h23: r = {1'b1, 8'h64}; 8'h24: r = {1'b1, 8'h65}; 8'h2B: r = {1'b1, 8'h66};
      8'h34: r = {1'b1, 8'h67}; 8'h33: r = {1'b1, 8'h68}; 8'h43: r = {1'b1, 8'h69};
      8'h3B: r = {1'b1, 8'h6A}; 8'h42: r = {1'b1, 8'h6B}; 8'h4B: r = {1'b1, 8'h6C};
      8'h3A: r = {1'b1, 8'h6D}; 8'h31: r = {1'b1, 8'h6E}; 8'h44: r = {1'b1, 8'h6F};
      8'h4D: r = {1'b1, 8'h70}; 8'h15: r = {1'b1, 8'h71}; 8'h2D: r = {1'b1, 8'h72};
      8'h1B: r = {1'b1, 8'h73}; 8'h2C: r = {1'b1, 8'h74}; 8'h3C: r = {1'b1, 8'h75};
      8'h2A: r = {1'b1, 8'h76}; 8'h1D: r = {1'b1, 8'h77}; 8'h22: r = {1'b1, 8'h78};
      8'h35: r = {1'b1, 8'h79}; 8'h1A: r = {1'b1, 8'h7A};
      8'h45: r = {1'b1, 8'h30}; 8'h16: r = {1'b1, 8'h31}; 8'h1E: r = {1'b1, 8'h32};
      8'h26: r = {1'b1, 8'h33}; 8'h25: r = {1'b1, 8'h34}; 8'h2E: r = {1'b1, 8'h35};
      8'h36: r = {1'b1, 8'h36}; 8'h3D: r = {1'b1, 8'h37}; 8'h3E: r = {1'b1, 8'h38};
      8'h46: r = {1'b1, 8'h39};
      8'h29: r = {1'b1, 8'h20}; 8'h5A: r = {1'b1, 8'h0D}; 8'h76: r = {1'b1, 8'h1B};
      default: r = '0;
    endcase
    return r;
  endfunction

  state_e      state_q;
  logic [2:0]  bitcnt_q;
  logic [7:0]  shreg_q;
  logic        par_q;
  logic [TW-1:0] tmo_q;
  logic        ext_q;
  logic        brk_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        done_q;
  logic        rst_q;
  logic        perr_q;
  logic [8:0]  lk;
  logic [7:0]  ascii;

`ifdef PS2_SHIFT_EN
  logic shift_l_q;
  logic shift_r_q;

  always_comb begin
    lk    = lookup(shreg_q);
    ascii = lk[7:0];
    if ((shift_l_q | shift_r_q) && lk[7:0] >= 8'h61 && lk[7:0] <= 8'h7A)
      ascii = lk[7:0] - 8'h20;
  end
`else
  always_comb begin
    lk    = lookup(shreg_q);
    ascii = lk[7:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      rst_q    <= 1'b0;
      perr_q   <= 1'b0;
`ifdef PS2_SHIFT_EN
      shift_l_q <= 1'b0;
      shift_r_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      rst_q   <= 1'b0;
      perr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tmo_q <= '0;
          if (fall && !dat_s) begin
            state_q  <= S_DATA;
            bitcnt_q <= '0;
          end
        end
        S_DATA, S_PARITY, S_STOP: begin
          if (fall) begin
            tmo_q <= '0;
            if (state_q == S_DATA) begin
              shreg_q  <= {dat_s, shreg_q[7:1]};
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) state_q <= S_PARITY;
            end else if (state_q == S_PARITY) begin
              par_q   <= dat_s;
              state_q <= S_STOP;
            end else if ((^shreg_q ^ par_q) && dat_s) begin
              state_q <= S_DECODE;
            end else begin
              perr_q  <= 1'b1;
              ext_q   <= 1'b0;
              brk_q   <= 1'b0;
              state_q <= S_IDLE;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_DECODE: begin
          state_q <= S_IDLE;
          if (shreg_q == 8'hE0) begin
            ext_q <= 1'b1;
          end else if (shreg_q == 8'hF0) begin
            brk_q <= 1'b1;
          end else if (brk_q) begin
            brk_q <= 1'b0;
            ext_q <= 1'b0;
`ifdef PS2_SHIFT_EN
            if (shreg_q == 8'h12) shift_l_q <= 1'b0;
            if (shreg_q == 8'h59) shift_r_q <= 1'b0;
`endif
          end else if (ext_q) begin
            ext_q <= 1'b0;
`ifdef PS2_SHIFT_EN
          end else if (shreg_q == 8'h12) begin
            shift_l_q <= 1'b1;
          end else if (shreg_q == 8'h59) begin
            shift_r_q <= 1'b1;
`endif
          end else if (lk[8]) begin
            data_q  <= ascii;
            valid_q <= 1'b1;
            done_q  <= (shreg_q == 8'h5A);
            rst_q   <= (shreg_q == 8'h76);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ps2_data_o   = data_q;
  assign ps2_valid_o  = valid_q;
  assign ps2_done_o   = done_q;
  assign ps2_reset_o  = rst_q;
  assign parity_err_o = perr_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: drives PS/2 frames and checks decoded pulses with immediate assertions.
module tb_ps2_keyboard_rx;
  localparam int unsigned TMO  = 5000;
  localparam int unsigned FL   = 4;
  localparam int unsigned HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] data;
  logic       valid, done, rstk, perr;

  ps2_keyboard_rx #(.TIMEOUT_CYCLES(TMO), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat),
    .ps2_data_o(data), .ps2_valid_o(valid), .ps2_done_o(done),
    .ps2_reset_o(rstk), .parity_err_o(perr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int unsigned fall_cyc = 0;

  int         n_valid = 0, n_done = 0, n_rst = 0, n_perr = 0, n_bad = 0, n_long = 0;
  logic [7:0] pulse_data [64];
  int unsigned valid_cyc = 0;
  logic       prev_valid = 1'b0;

  always @(negedge clk) begin
    if (valid) begin
      if (n_valid < 64) pulse_data[n_valid] = data;
      if (!prev_valid) valid_cyc = cyc;
      n_valid++;
      if (done) n_done++;
      if (rstk) n_rst++;
    end
    if (done && rstk) n_bad++;
    if ((done || rstk) && !valid) n_bad++;
    if (valid && prev_valid) n_long++;
    prev_valid = valid;
    if (perr) n_perr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] b);
    send(b, 1'b0, 1'b0, 11);
  endtask

  int base;
  int pbase;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_data", {24'b0, data}, 32'h00);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_rst", {31'b0, rstk}, 32'd0);
    check("reset_perr", {31'b0, perr}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    key(8'h1C);
    check("a_count", n_valid, 1);
    check("a_data", {24'b0, pulse_data[0]}, 32'h61);
    check("a_done_rst", n_done + n_rst, 0);
    check("a_latency", valid_cyc - fall_cyc, FL + 4);

    key(8'hF0); key(8'h1C);
    check("release_count", n_valid, 1);
    check("data_hold", {24'b0, data}, 32'h61);

    base = n_valid;
    key(8'h12); key(8'h1C); key(8'hF0); key(8'h12); key(8'h1C);
    check("shift_count", n_valid - base, 2);
`ifdef PS2_SHIFT_EN
    check("shift_first", {24'b0, pulse_data[base]}, 32'h41);
`else
    check("shift_first", {24'b0, pulse_data[base]}, 32'h61);
`endif
    check("shift_second", {24'b0, pulse_data[base + 1]}, 32'h61);

    base = n_valid;
    key(8'h5A);
    check("enter_count", n_valid - base, 1);
    check("enter_data", {24'b0, pulse_data[base]}, 32'h0D);
    check("enter_done", n_done, 1);
    key(8'h76);
    check("esc_data", {24'b0, pulse_data[base + 1]}, 32'h1B);
    check("esc_rst", n_rst, 1);
    check("esc_done_unchanged", n_done, 1);

    base = n_valid; pbase = n_perr;
    send(8'h1C, 1'b1, 1'b0, 11);
    check("badpar_perr", n_perr - pbase, 1);
    check("badpar_novalid", n_valid - base, 0);
    key(8'h32);
    check("after_badpar_data", {24'b0, pulse_data[base]}, 32'h62);

    base = n_valid; pbase = n_perr;
    send(8'h1C, 1'b0, 1'b1, 11);
    check("badstop_perr", n_perr - pbase, 1);
    check("badstop_novalid", n_valid - base, 0);

    base = n_valid;
    send(8'h1C, 1'b0, 1'b0, 5);
    repeat (TMO + 10) @(negedge clk);
    key(8'h29);
    check("timeout_count", n_valid - base, 1);
    check("timeout_data", {24'b0, pulse_data[base]}, 32'h20);

    base = n_valid; pbase = n_perr;
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    key(8'h1C);
    check("glitch_count", n_valid - base, 1);
    check("glitch_data", {24'b0, pulse_data[base]}, 32'h61);
    check("glitch_perr", n_perr - pbase, 0);

    base = n_valid;
    key(8'hE0); key(8'h5A);
    key(8'hE0); key(8'hF0); key(8'h5A);
    key(8'h05);
    check("ext_dropped", n_valid - base, 0);
    key(8'h1C);
    check("ext_cleared_data", {24'b0, pulse_data[base]}, 32'h61);

    base = n_valid;
    key(8'h4D); key(8'h4D);
    check("typematic_count", n_valid - base, 2);
    check("typematic_data", {24'b0, pulse_data[base + 1]}, 32'h70);

    base = n_valid;
    send(8'h3A, 1'b0, 1'b0, 4);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_data", {24'b0, data}, 32'h00);
    check("midreset_valid", {31'b0, valid}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    key(8'h24);
    check("midreset_count", n_valid - base, 1);
    check("midreset_after", {24'b0, pulse_data[base]}, 32'h65);

    check("done_rst_exclusive", n_bad, 0);
    check("one_cycle_pulses", n_long, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
